// File: rtl/color_toggle_sequencer.sv
// Button debounce plus optional auto-cycle timer, merged into a single
// registered toggle_color strobe with a mirrored pattern_sel.
module color_toggle_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int AUTO_PERIOD     = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic auto_en,
  output logic toggle_color,
  output logic pattern_sel,
  output logic btn_level
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW = $clog2(AUTO_PERIOD + 1);

  localparam logic [DW-1:0] DB_END = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_ONE = DW'(1);
  localparam logic [AW-1:0] AP_END = AW'(AUTO_PERIOD - 1);
  localparam logic [AW-1:0] AP_ONE = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    PRESSED,
    RELEASING
  } db_state_e;

  db_state_e state_q;
  db_state_e state_d;

  logic          btn_s1;
  logic          btn_s;
  logic [DW-1:0] db_cnt_q;
  logic [DW-1:0] db_cnt_d;
  logic [AW-1:0] ap_cnt_q;
  logic [AW-1:0] ap_cnt_d;
  logic          press_req;
  logic          auto_req;
  logic          strobe_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1 <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s  <= btn_s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      db_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // A full count of stable samples is decisive, checked before the level.
  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    press_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d  = ARMING;
          db_cnt_d = DB_ONE;
        end
      end
      ARMING: begin
        if (db_cnt_q == DB_END) begin
          state_d   = PRESSED;
          db_cnt_d  = '0;
          press_req = 1'b1;
        end else if (!btn_s) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d  = RELEASING;
          db_cnt_d = DB_ONE;
        end
      end
      RELEASING: begin
        if (db_cnt_q == DB_END) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (btn_s) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  assign btn_level = (state_q == PRESSED) ||
                     (state_q == RELEASING);

  assign auto_req = auto_en && (ap_cnt_q == AP_END);

  // A press restarts the period so the next auto strobe is a full period out.
  always_comb begin
    ap_cnt_d = ap_cnt_q + AP_ONE;
    if (!auto_en || press_req || auto_req) begin
      ap_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ap_cnt_q <= '0;
    end else begin
      ap_cnt_q <= ap_cnt_d;
    end
  end

  assign strobe_req = press_req | auto_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      toggle_color <= 1'b0;
      pattern_sel  <= 1'b0;
    end else begin
      toggle_color <= strobe_req;
      pattern_sel  <= pattern_sel ^ strobe_req;
    end
  end

endmodule
